// File: rtl/victim_way_sel_pkg.sv
// Shared types for the cache-refill victim selector: FSM state encoding,
// victim result record and a binary-to-one-hot helper sized for the widest set.
package victim_sel_pkg;

  localparam int unsigned MaxWays    = 16;
  localparam int unsigned MaxLogWays = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    RESP
  } state_e;

  // Sized for MaxWays; users slice down to their own NR_WAYS / LogWays.
  typedef struct packed {
    logic [MaxWays-1:0]    oh;
    logic [MaxLogWays-1:0] bin;
    logic                  evict;
    logic                  err;
  } victim_t;

  function automatic logic [MaxWays-1:0] bin2oh(input logic [MaxLogWays-1:0] bin);
    logic [MaxWays-1:0] oh;
    oh      = '0;
    oh[bin] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/victim_way_sel_if.sv
// Request (miss handler) and victim (refill/evict datapath) handshakes of the
// victim selector; slave is the selector side, master the surrounding logic.
interface victim_way_sel_if #(
  parameter int unsigned NR_WAYS = 8
);
  localparam int unsigned LogWays = $clog2(NR_WAYS);

  logic               req_valid_i;
  logic               req_ready_o;
  logic [NR_WAYS-1:0] req_valid_ways_i;
  logic [NR_WAYS-1:0] req_lock_ways_i;
  logic               victim_valid_o;
  logic               victim_ready_i;
  logic [NR_WAYS-1:0] victim_way_oh_o;
  logic [LogWays-1:0] victim_way_bin_o;
  logic               victim_evict_o;
  logic               victim_err_o;

  modport slave (
    input  req_valid_i, req_valid_ways_i, req_lock_ways_i, victim_ready_i,
    output req_ready_o, victim_valid_o, victim_way_oh_o, victim_way_bin_o,
           victim_evict_o, victim_err_o
  );

  modport master (
    output req_valid_i, req_valid_ways_i, req_lock_ways_i, victim_ready_i,
    input  req_ready_o, victim_valid_o, victim_way_oh_o, victim_way_bin_o,
           victim_evict_o, victim_err_o
  );

endinterface

// File: rtl/victim_way_sel_lzc.sv
// Leading/trailing zero counter. MODE=0 returns the index of the lowest set bit,
// MODE=1 the number of leading zeros; empty_o flags an all-zero input.
module lzc #(
  parameter int unsigned WIDTH = 8,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);

  // Scan from lowest to highest priority so the last hit written wins.
  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (MODE) begin
        if (in_i[i]) cnt_o = CntW'(WIDTH - 1 - i);
      end else begin
        if (in_i[WIDTH-1-i]) cnt_o = CntW'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/victim_way_sel.sv
// Cache-refill victim selector: prefers the lowest free unlocked way, otherwise
// draws ways from an external LFSR, retrying locked draws before a fixed fallback.
module victim_way_sel
  import victim_sel_pkg::*;
#(
  parameter int unsigned NR_WAYS   = 8,
  parameter int unsigned MAX_RETRY = 4,
  localparam int unsigned LogWays  = $clog2(NR_WAYS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  victim_way_sel_if.slave    bus,
  input  logic [LogWays-1:0] lfsr_way_bin_i,
  output logic               lfsr_en_o
);

  localparam int unsigned RetryW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RetryW-1:0] LastRetry = RetryW'(MAX_RETRY - 1);

  if (NR_WAYS < 2 || NR_WAYS > MaxWays || (NR_WAYS & (NR_WAYS - 1)) != 0 || MAX_RETRY < 1)
  begin : g_param_check
    $error("victim_way_sel: NR_WAYS must be a power of two in 2..16 and MAX_RETRY >= 1");
  end

  state_e             state_q;
  logic [RetryW-1:0]  retry_q;
  logic [NR_WAYS-1:0] valid_q;
  logic [NR_WAYS-1:0] lock_q;
  victim_t            victim_q;
  logic               victim_valid_q;
  logic               req_ready_q;

  logic [NR_WAYS-1:0] free_ways;
  logic [NR_WAYS-1:0] unlocked_ways;
  logic [LogWays-1:0] free_idx;
  logic [LogWays-1:0] unlocked_idx;
  logic               free_empty;
  logic               all_locked;
  logic               lfsr_locked;

  victim_t            nxt;
  logic               search_done;
  logic               search_en;

  assign free_ways     = ~valid_q & ~lock_q;
  assign unlocked_ways = ~lock_q;
  assign lfsr_locked   = lock_q[lfsr_way_bin_i];

  lzc #(
    .WIDTH (NR_WAYS),
    .MODE  (1'b0)
  ) i_lzc_free (
    .in_i    (free_ways),
    .cnt_o   (free_idx),
    .empty_o (free_empty)
  );

  lzc #(
    .WIDTH (NR_WAYS),
    .MODE  (1'b0)
  ) i_lzc_unlocked (
    .in_i    (unlocked_ways),
    .cnt_o   (unlocked_idx),
    .empty_o (all_locked)
  );

  // Victim decision for the current SEARCH cycle, in priority order.
  always_comb begin
    nxt         = '0;
    search_done = 1'b0;
    search_en   = 1'b0;
    if (all_locked) begin
      nxt.err     = 1'b1;
      search_done = 1'b1;
    end else if (!free_empty) begin
      nxt.bin     = MaxLogWays'(free_idx);
      search_done = 1'b1;
    end else if (!lfsr_locked) begin
      nxt.bin     = MaxLogWays'(lfsr_way_bin_i);
      nxt.evict   = 1'b1;
      search_done = 1'b1;
      search_en   = 1'b1;
    end else begin
      search_en = 1'b1;
      if (retry_q == LastRetry) begin
        nxt.bin     = MaxLogWays'(unlocked_idx);
        nxt.evict   = 1'b1;
        search_done = 1'b1;
      end
    end
    if (!nxt.err) nxt.oh = bin2oh(nxt.bin);
  end

  // Gated by reset so an aborted search never advances the LFSR.
  assign lfsr_en_o = rst_ni && (state_q == SEARCH) && search_en;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      retry_q        <= '0;
      valid_q        <= '0;
      lock_q         <= '0;
      victim_q       <= '0;
      victim_valid_q <= 1'b0;
      req_ready_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            valid_q     <= bus.req_valid_ways_i;
            lock_q      <= bus.req_lock_ways_i;
            retry_q     <= '0;
            req_ready_q <= 1'b0;
            state_q     <= SEARCH;
          end
        end
        SEARCH: begin
          if (search_done) begin
            victim_q       <= nxt;
            victim_valid_q <= 1'b1;
            state_q        <= RESP;
          end else begin
            retry_q <= retry_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.victim_ready_i) begin
            victim_valid_q <= 1'b0;
            req_ready_q    <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o      = req_ready_q;
  assign bus.victim_valid_o   = victim_valid_q;
  assign bus.victim_way_oh_o  = victim_q.oh[NR_WAYS-1:0];
  assign bus.victim_way_bin_o = victim_q.bin[LogWays-1:0];
  assign bus.victim_evict_o   = victim_q.evict;
  assign bus.victim_err_o     = victim_q.err;

  logic unused_bits;
  assign unused_bits = ^{victim_q.oh, victim_q.bin};

endmodule
